decode_ctrl_seq: RTL

Registered, handshaked successor to the combinational main decoder. It turns one 32-bit RV32 instruction into the same control bundle the datapath already consumes, and adds strict funct3/funct7 legality checking and build-time ISA-extension parameters. A small FSM splits A-extension AMO read-modify-write instructions into two sequential micro-ops (read phase, write phase). It sits between fetch/IF-ID and execute, replacing the i_Stall input with valid/ready flow control.

---
 rtl/decode_ctrl_seq.sv | 287 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/decode_ctrl_seq.sv
// Registered RV32 main decoder with valid/ready flow control.
// Ports: i_clk/i_rstn; i_instr+i_valid/o_ready in; o_valid/i_ready out; i_flush kill; o_* control bundle.
module decode_ctrl_seq #(
    parameter bit EN_ATOMIC     = 1'b1,
    parameter bit EN_M          = 1'b1,
    parameter bit STRICT_DECODE = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic [31:0] i_instr,
    input  logic        i_valid,
    output logic        o_ready,
    output logic        o_valid,
    input  logic        i_ready,
    input  logic        i_flush,
    output logic        o_branch,
    output logic        o_mem_read,
    output logic        o_mem_write,
    output logic        o_mem_to_reg,
    output logic        o_alu_src_b,
    output logic        o_reg_write,
    output logic        o_pc_plus4,
    output logic        o_csr_en,
    output logic        o_illegal,
    output logic        o_atomic,
    output logic        o_alum_en,
    output logic [2:0]  o_alu_op,
    output logic [1:0]  o_alu_src_a,
    output logic [1:0]  o_jump,
    output logic [1:0]  o_amo_phase
);

    typedef struct packed {
        logic       branch;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       alu_src_b;
        logic       reg_write;
        logic       pc_plus4;
        logic       csr_en;
        logic       illegal;
        logic       atomic;
        logic       alum_en;
        logic [2:0] alu_op;
        logic [1:0] alu_src_a;
        logic [1:0] jump;
        logic [1:0] amo_phase;
    } ctl_t;

    typedef enum logic {IDLE, AMO_WR} state_t;

    state_t state;
    logic   valid;
    ctl_t   ctl;
    ctl_t   dec;
    ctl_t   wr_beat;
    logic   is_rmw;
    logic   rmw_raw;
    logic   legal;
    logic   accept;

    logic [6:0] opc;
    logic [6:0] f7;
    logic [2:0] f3;
    logic [4:0] f5;

    assign opc = i_instr[6:0];
    assign f3  = i_instr[14:12];
    assign f7  = i_instr[31:25];
    assign f5  = i_instr[31:27];

    // Register/immediate fields are consumed downstream, not here.
    logic unused_fields;
    assign unused_fields = ^{i_instr[24:15], i_instr[11:7]};

    logic is_op, is_opimm, is_load, is_store, is_branch;
    logic is_lui, is_auipc, is_jal, is_jalr, is_fence;
    logic is_system, is_amo;

    assign is_op     = opc == 7'b0110011;
    assign is_opimm  = opc == 7'b0010011;
    assign is_load   = opc == 7'b0000011;
    assign is_store  = opc == 7'b0100011;
    assign is_branch = opc == 7'b1100011;
    assign is_lui    = opc == 7'b0110111;
    assign is_auipc  = opc == 7'b0010111;
    assign is_jal    = opc == 7'b1101111;
    assign is_jalr   = opc == 7'b1100111;
    assign is_fence  = opc == 7'b0001111;
    assign is_system = opc == 7'b1110011;
    assign is_amo    = opc == 7'b0101111;

    logic amo_lr, amo_sc, amo_rmw_f5;
    assign amo_lr     = f5 == 5'b00010;
    assign amo_sc     = f5 == 5'b00011;
    assign amo_rmw_f5 = f5 inside {5'b00001, 5'b00000, 5'b00100,
                                   5'b01100, 5'b01000, 5'b10000,
                                   5'b10100, 5'b11000, 5'b11100};

    always_comb begin
        dec     = '0;
        rmw_raw = 1'b0;
        legal   = 1'b1;
        unique case (1'b1)
            is_op: begin
                dec.reg_write = 1'b1;
                dec.alu_op    = 3'b010;
                dec.alum_en   = EN_M && (f7 == 7'b0000001);
                if (STRICT_DECODE)
                    legal = (f7 == 7'b0000000) ||
                            (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)) ||
                            (f7 == 7'b0000001 && EN_M);
                else
                    legal = !(f7 == 7'b0000001 && !EN_M);
            end
            is_opimm: begin
                dec.alu_src_b = 1'b1;
                dec.reg_write = 1'b1;
                dec.alu_op    = 3'b011;
                if (STRICT_DECODE && f3 == 3'b001)
                    legal = f7 == 7'b0000000;
                else if (STRICT_DECODE && f3 == 3'b101)
                    legal = f7 == 7'b0000000 || f7 == 7'b0100000;
            end
            is_load: begin
                dec.mem_read   = 1'b1;
                dec.mem_to_reg = 1'b1;
                dec.alu_src_b  = 1'b1;
                dec.reg_write  = 1'b1;
                if (STRICT_DECODE)
                    legal = f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
            end
            is_store: begin
                dec.mem_write = 1'b1;
                dec.alu_src_b = 1'b1;
                if (STRICT_DECODE)
                    legal = f3 inside {3'b000, 3'b001, 3'b010};
            end
            is_branch: begin
                dec.branch = 1'b1;
                dec.alu_op = 3'b001;
                if (STRICT_DECODE)
                    legal = !(f3 inside {3'b010, 3'b011});
            end
            is_lui: begin
                dec.alu_src_a = 2'd2;
                dec.alu_src_b = 1'b1;
                dec.reg_write = 1'b1;
                dec.alu_op    = 3'b100;
            end
            is_auipc: begin
                dec.alu_src_a = 2'd1;
                dec.alu_src_b = 1'b1;
                dec.reg_write = 1'b1;
                dec.alu_op    = 3'b100;
            end
            is_jal: begin
                dec.reg_write = 1'b1;
                dec.jump      = 2'd1;
                dec.pc_plus4  = 1'b1;
            end
            is_jalr: begin
                dec.alu_src_b = 1'b1;
                dec.reg_write = 1'b1;
                dec.alu_op    = 3'b100;
                dec.jump      = 2'd2;
                dec.pc_plus4  = 1'b1;
                if (STRICT_DECODE)
                    legal = f3 == 3'b000;
            end
            is_fence: begin
                legal = 1'b1;
            end
            is_system: begin
                dec.mem_to_reg = 1'b1;
                dec.reg_write  = 1'b1;
                dec.alu_op     = 3'b101;
                dec.csr_en     = 1'b1;
            end
            is_amo: begin
                if (!EN_ATOMIC) begin
                    legal = 1'b0;
                end else begin
                    dec.atomic = 1'b1;
                    dec.alu_op = 3'b101;
                    if (amo_lr) begin
                        dec.mem_read   = 1'b1;
                        dec.mem_to_reg = 1'b1;
                        dec.reg_write  = 1'b1;
                    end else if (amo_sc) begin
                        dec.mem_read   = 1'b1;
                        dec.mem_write  = 1'b1;
                        dec.mem_to_reg = 1'b1;
                        dec.reg_write  = 1'b1;
                    end else begin
                        rmw_raw = 1'b1;
                    end
                    if (STRICT_DECODE)
                        legal = f3 == 3'b010 && (amo_lr || amo_sc || amo_rmw_f5);
                end
            end
            default: begin
                legal = 1'b0;
            end
        endcase

        is_rmw = legal && rmw_raw;
        if (!legal) begin
            dec         = '0;
            dec.illegal = 1'b1;
        end else if (rmw_raw) begin
            // First beat of a read-modify-write AMO: the load half.
            dec            = '0;
            dec.mem_read   = 1'b1;
            dec.mem_to_reg = 1'b1;
            dec.reg_write  = 1'b1;
            dec.atomic     = 1'b1;
            dec.alu_op     = 3'b101;
            dec.amo_phase  = 2'd1;
        end
    end

    always_comb begin
        wr_beat           = '0;
        wr_beat.mem_write = 1'b1;
        wr_beat.atomic    = 1'b1;
        wr_beat.alu_op    = 3'b110;
        wr_beat.amo_phase = 2'd2;
    end

    assign o_ready = i_rstn && !i_flush && state == IDLE && (!valid || i_ready);
    assign accept  = i_valid && o_ready;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state <= IDLE;
            valid <= 1'b0;
            ctl   <= '0;
        end else if (i_flush) begin
            state <= IDLE;
            valid <= 1'b0;
            ctl   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        ctl   <= dec;
                        valid <= 1'b1;
                        state <= is_rmw ? AMO_WR : IDLE;
                    end else if (i_ready) begin
                        ctl   <= '0;
                        valid <= 1'b0;
                    end
                end
                AMO_WR: begin
                    // Swap in the store half once the load half is taken.
                    if (valid && i_ready) begin
                        ctl   <= wr_beat;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign o_valid      = valid;
    assign o_branch     = ctl.branch;
    assign o_mem_read   = ctl.mem_read;
    assign o_mem_write  = ctl.mem_write;
    assign o_mem_to_reg = ctl.mem_to_reg;
    assign o_alu_src_b  = ctl.alu_src_b;
    assign o_reg_write  = ctl.reg_write;
    assign o_pc_plus4   = ctl.pc_plus4;
    assign o_csr_en     = ctl.csr_en;
    assign o_illegal    = ctl.illegal;
    assign o_atomic     = ctl.atomic;
    assign o_alum_en    = ctl.alum_en;
    assign o_alu_op     = ctl.alu_op;
    assign o_alu_src_a  = ctl.alu_src_a;
    assign o_jump       = ctl.jump;
    assign o_amo_phase  = ctl.amo_phase;

endmodule
